// File: rtl/pw_weight_pkg.sv
// Shared definitions for the pointwise weight loader and the weight bank it feeds.
// Address width derives from the same helpers on both sides so the two always agree.
package pw_weight_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } pw_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int total_weights(input int cin, input int cout);
        return cin * cout;
    endfunction

    function automatic int waddr_w(input int total);
        return idx_w(total);
    endfunction

    function automatic int num_beats(input int total, input int lanes);
        return (total + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/weight_beat_serializer.sv
// Holds one packed beat and presents its lanes one per cycle, lane 0 first.
// final_i frees the buffer early when the presented lane is the last weight of the load.
module weight_beat_serializer
    import pw_weight_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    localparam int LANE_W = idx_w(LANES)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      flush_i,
    input  logic                      load_i,
    input  logic [LANES*DATA_W-1:0]   data_i,
    input  logic                      final_i,
    output logic                      buf_valid_o,
    output logic [DATA_W-1:0]         lane_data_o,
    output logic                      ready_o
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    logic [LANES*DATA_W-1:0] buf_q, buf_d;
    logic [LANE_W-1:0]       lane_idx_q, lane_idx_d;
    logic                    buf_valid_q, buf_valid_d;
    logic                    last_lane;

    assign last_lane   = (lane_idx_q == LAST_LANE);
    assign ready_o     = !buf_valid_q || last_lane;
    assign buf_valid_o = buf_valid_q;
    assign lane_data_o = buf_q[int'(lane_idx_q) * DATA_W +: DATA_W];

    always_comb begin
        buf_d       = buf_q;
        lane_idx_d  = lane_idx_q;
        buf_valid_d = buf_valid_q;
        if (flush_i) begin
            buf_valid_d = 1'b0;
            lane_idx_d  = '0;
        end else begin
            if (buf_valid_q) begin
                if (last_lane || final_i) begin
                    buf_valid_d = 1'b0;
                    lane_idx_d  = '0;
                end else begin
                    lane_idx_d = lane_idx_q + 1'b1;
                end
            end
            // A new beat lands in the same cycle the old one drains its last lane.
            if (load_i) begin
                buf_d       = data_i;
                buf_valid_d = 1'b1;
                lane_idx_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            buf_q       <= '0;
            lane_idx_q  <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            lane_idx_q  <= lane_idx_d;
            buf_valid_q <= buf_valid_d;
        end
    end

endmodule

// File: rtl/pointwise_weight_loader.sv
// Streams packed weight beats into the pointwise weight bank, one weight per cycle at
// sequential addresses. reset_i is active-low and synchronous.
//
// state | meaning
// IDLE  | waiting for start, no stream traffic accepted
// LOAD  | accepting beats and writing weights to the bank
// DONE  | one-cycle completion pulse after the final write
module pointwise_weight_loader
    import pw_weight_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CIN    = 32,
    parameter int COUT   = 64,
    parameter int LANES  = 4,
    localparam int TOTAL   = total_weights(CIN, COUT),
    localparam int WADDR_W = waddr_w(TOTAL)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic [LANES*DATA_W-1:0]   s_data_i,
    output logic                      wr_en_o,
    output logic [WADDR_W-1:0]        wr_addr_o,
    output logic [DATA_W-1:0]         wr_data_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int NBEATS = num_beats(TOTAL, LANES);
    localparam int BCNT_W = $clog2(NBEATS + 1);
    localparam logic [WADDR_W-1:0] LAST_ADDR = WADDR_W'(TOTAL - 1);
    localparam logic [BCNT_W-1:0]  NBEATS_V  = BCNT_W'(NBEATS);

    pw_state_e state_q, state_d;

    logic [WADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [BCNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [WADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;

    logic              buf_valid;
    logic [DATA_W-1:0] lane_data;
    logic              ser_ready;
    logic              start_load;
    logic              flush;
    logic              xfer;
    logic              emit;
    logic              final_lane;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i) state_d = LOAD;
            LOAD: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (state_q != IDLE);
        done_o    = (state_q == DONE);
        s_ready_o = (state_q == LOAD) && (beat_cnt_q != NBEATS_V) && ser_ready;
    end

    assign start_load = (state_q == IDLE) && start_i;
    assign flush      = start_load || ((state_q == LOAD) && abort_i);
    // Abort drops a beat offered in the same cycle even though ready was shown.
    assign xfer       = s_valid_i && s_ready_o && !abort_i;
    assign emit       = buf_valid && (state_q == LOAD) && !abort_i;
    assign final_lane = (wr_cnt_q == LAST_ADDR);

    weight_beat_serializer #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_ser (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (flush),
        .load_i      (xfer),
        .data_i      (s_data_i),
        .final_i     (final_lane),
        .buf_valid_o (buf_valid),
        .lane_data_o (lane_data),
        .ready_o     (ser_ready)
    );

    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        beat_cnt_d = beat_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (start_load) begin
            wr_cnt_d   = '0;
            beat_cnt_d = '0;
        end else if (emit) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_cnt_q;
            wr_data_d = lane_data;
            if (!final_lane) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
        if (xfer) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_cnt_q   <= '0;
            beat_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_pointwise_weight_loader.sv
// Bench for pointwise_weight_loader: a default-size instance and a small partial-beat instance,
// both checked every cycle against a timed write-queue reference model.
module tb_pointwise_weight_loader;

    localparam int DW     = 8;
    localparam int LN     = 4;
    localparam int A_CIN  = 32;
    localparam int A_COUT = 64;
    localparam int B_CIN  = 3;
    localparam int B_COUT = 2;
    localparam int A_AW   = 11;
    localparam int B_AW   = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic            start_a = 1'b0, abort_a = 1'b0, valid_a = 1'b0;
    logic [LN*DW-1:0] data_a = '0;
    logic            ready_a, wr_en_a, busy_a, done_a;
    logic [A_AW-1:0] addr_a;
    logic [DW-1:0]   wdata_a;

    logic            start_b = 1'b0, abort_b = 1'b0, valid_b = 1'b0;
    logic [LN*DW-1:0] data_b = '0;
    logic            ready_b, wr_en_b, busy_b, done_b;
    logic [B_AW-1:0] addr_b;
    logic [DW-1:0]   wdata_b;

    pointwise_weight_loader #(.DATA_W(DW), .CIN(A_CIN), .COUT(A_COUT), .LANES(LN)) dut_a (
        .clk_i(clk), .reset_i(reset_n), .start_i(start_a), .abort_i(abort_a),
        .s_valid_i(valid_a), .s_ready_o(ready_a), .s_data_i(data_a),
        .wr_en_o(wr_en_a), .wr_addr_o(addr_a), .wr_data_o(wdata_a),
        .busy_o(busy_a), .done_o(done_a)
    );

    pointwise_weight_loader #(.DATA_W(DW), .CIN(B_CIN), .COUT(B_COUT), .LANES(LN)) dut_b (
        .clk_i(clk), .reset_i(reset_n), .start_i(start_b), .abort_i(abort_b),
        .s_valid_i(valid_b), .s_ready_o(ready_b), .s_data_i(data_b),
        .wr_en_o(wr_en_b), .wr_addr_o(addr_b), .wr_data_o(wdata_b),
        .busy_o(busy_b), .done_o(done_b)
    );

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t qa[$];
    wr_t qb[$];
    int  cyc = 0;
    int  tot[2] = '{A_CIN * A_COUT, B_CIN * B_COUT};
    int  nb[2]  = '{(A_CIN * A_COUT + LN - 1) / LN, (B_CIN * B_COUT + LN - 1) / LN};
    int  m_st[2], m_acc[2], m_nxt[2], m_haddr[2], m_hdata[2];
    int  done_cnt[2], run_cur[2], run_max[2], wr_obs[2];
    bit  chk_en = 1'b0;
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 50) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: every accepted beat schedules lane k at (accept cycle + 2 + k), truncated at TOTAL.
    task automatic model_step(input int i, input logic en, input int addr, input int data,
                              input logic rdy, input logic busy, input logic done,
                              input logic st_in, input logic ab_in, input logic v_in,
                              input logic [LN*DW-1:0] d_in);
        wr_t   front, e;
        bit    exp_en, exp_rdy;
        int    qsize, last_cyc;
        string p;
        p = (i == 0) ? "a" : "b";
        qsize = (i == 0) ? qa.size() : qb.size();
        last_cyc = 0;
        front = '{0, 0, 0};
        if (qsize > 0) begin
            front    = (i == 0) ? qa[0] : qb[0];
            last_cyc = (i == 0) ? qa[qsize-1].cyc : qb[qsize-1].cyc;
        end
        exp_en  = (qsize > 0) && (front.cyc == cyc);
        exp_rdy = (m_st[i] == 1) && (m_acc[i] < nb[i]) && ((qsize == 0) || (last_cyc <= cyc + 1));
        if (exp_en) begin
            m_haddr[i] = front.addr;
            m_hdata[i] = front.data;
            if (i == 0) void'(qa.pop_front()); else void'(qb.pop_front());
        end
        chk({p, "_wr_en"},   en,   exp_en);
        chk({p, "_wr_addr"}, addr, m_haddr[i]);
        chk({p, "_wr_data"}, data, m_hdata[i]);
        chk({p, "_s_ready"}, rdy,  exp_rdy);
        chk({p, "_busy"},    busy, m_st[i] != 0);
        chk({p, "_done"},    done, m_st[i] == 2);
        if (en) begin
            wr_obs[i]++;
            run_cur[i]++;
            if (run_cur[i] > run_max[i]) run_max[i] = run_cur[i];
        end else begin
            run_cur[i] = 0;
        end
        if (done) done_cnt[i]++;

        if (!reset_n) begin
            m_st[i] = 0; m_acc[i] = 0; m_nxt[i] = 0; m_haddr[i] = 0; m_hdata[i] = 0;
            if (i == 0) qa.delete(); else qb.delete();
        end else begin
            case (m_st[i])
                0: if (st_in) begin
                    m_st[i] = 1; m_acc[i] = 0; m_nxt[i] = 0;
                    if (i == 0) qa.delete(); else qb.delete();
                end
                1: if (ab_in) begin
                    m_st[i] = 0;
                    if (i == 0) qa.delete(); else qb.delete();
                end else begin
                    if (exp_en && front.addr == tot[i] - 1) m_st[i] = 2;
                    if (v_in && exp_rdy) begin
                        for (int k = 0; k < LN; k++) begin
                            if (m_nxt[i] < tot[i]) begin
                                e.cyc  = cyc + 2 + k;
                                e.addr = m_nxt[i];
                                e.data = int'(d_in[k*DW +: DW]);
                                if (i == 0) qa.push_back(e); else qb.push_back(e);
                                m_nxt[i]++;
                            end
                        end
                        m_acc[i]++;
                    end
                end
                default: m_st[i] = 0;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            model_step(0, wr_en_a, int'(addr_a), int'(wdata_a), ready_a, busy_a, done_a,
                       start_a, abort_a, valid_a, data_a);
            model_step(1, wr_en_b, int'(addr_b), int'(wdata_b), ready_b, busy_b, done_b,
                       start_b, abort_b, valid_b, data_b);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_acc[i] = 0; m_nxt[i] = 0; m_haddr[i] = 0; m_hdata[i] = 0;
            done_cnt[i] = 0; run_cur[i] = 0; run_max[i] = 0; wr_obs[i] = 0;
        end

        // Reset held with start and valid asserted
        reset_n = 1'b0; start_a = 1'b1; valid_a = 1'b1; start_b = 1'b1; valid_b = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        tick(2);
        reset_n = 1'b1; start_a = 1'b0; valid_a = 1'b0; start_b = 1'b0; valid_b = 1'b0;
        tick(3);
        chk("a_idle_after_reset", busy_a, 1'b0);

        // Single beat
        wr_obs[0] = 0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        valid_a = 1'b1; data_a = 32'h04030201; tick(); valid_a = 1'b0;
        tick(6);
        chk("a_single_writes", wr_obs[0], 4);
        abort_a = 1'b1; tick(); abort_a = 1'b0; tick(2);

        // Full load, valid always high
        run_max[0] = 0; done_cnt[0] = 0; wr_obs[0] = 0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        valid_a = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            data_a = $urandom;
            tick();
            if (done_a) seen = 1'b1;
        end
        valid_a = 1'b0;
        chk("a_full_done_seen", seen, 1'b1);
        tick(2);
        chk("a_full_run_len", run_max[0], 2048);
        chk("a_full_writes", wr_obs[0], 2048);
        chk("a_full_done_cnt", done_cnt[0], 1);

        // Gaps (1,0,0,1 then random) with stray start pulses
        done_cnt[0] = 0; wr_obs[0] = 0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12000 && !seen; c++) begin
            valid_a = (c < 1200) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'($urandom_range(0, 1));
            data_a  = $urandom;
            start_a = ($urandom_range(0, 15) == 0);
            tick();
            if (done_a) seen = 1'b1;
        end
        start_a = 1'b0; valid_a = 1'b0;
        chk("a_gap_done_seen", seen, 1'b1);
        tick(2);
        chk("a_gap_writes", wr_obs[0], 2048);
        chk("a_gap_done_cnt", done_cnt[0], 1);

        // Abort when addr 10 is presented, with a beat offered in the same cycle
        done_cnt[0] = 0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        valid_a = 1'b1; seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            data_a = $urandom;
            tick();
            if (wr_en_a && addr_a == 11'd10) seen = 1'b1;
        end
        chk("a_abort_reach10", seen, 1'b1);
        abort_a = 1'b1; tick(); abort_a = 1'b0; valid_a = 1'b0;
        tick(3);
        chk("a_abort_busy", busy_a, 1'b0);
        chk("a_abort_done_cnt", done_cnt[0], 0);

        // Restart after abort, then reset at addr 10
        start_a = 1'b1; tick(); start_a = 1'b0;
        valid_a = 1'b1; seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            data_a = $urandom;
            tick();
            if (wr_en_a && addr_a == 11'd10) seen = 1'b1;
        end
        chk("a_reset_reach10", seen, 1'b1);
        reset_n = 1'b0; tick(); reset_n = 1'b1; valid_a = 1'b0;
        tick(3);
        chk("a_reset_busy", busy_a, 1'b0);
        chk("a_reset_addr", addr_a, 0);
        chk("a_reset_done_cnt", done_cnt[0], 0);

        // Partial final beat on the small instance
        done_cnt[1] = 0; wr_obs[1] = 0;
        start_b = 1'b1; tick(); start_b = 1'b0;
        valid_b = 1'b1; data_b = 32'h44332211; tick();
        data_b = 32'h88776655;
        tick(10);
        valid_b = 1'b0;
        tick(3);
        chk("b_part_writes", wr_obs[1], 6);
        chk("b_part_done_cnt", done_cnt[1], 1);
        chk("b_part_last_data", wdata_b, 8'h66);

        // Random loads with occasional abort on the small instance
        for (int r = 0; r < 20; r++) begin
            start_b = 1'b1; tick(); start_b = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 200 && !seen; c++) begin
                valid_b = 1'($urandom_range(0, 1));
                data_b  = $urandom;
                abort_b = ($urandom_range(0, 39) == 0);
                tick();
                if (done_b || !busy_b) seen = 1'b1;
            end
            valid_b = 1'b0; abort_b = 1'b0;
            chk("b_rand_end", seen, 1'b1);
            tick(2);
        end

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
